// File: rtl/read_request_scheduler_if.sv
// Handshake bundle between the read request scheduler, its requesters, the memory
// read port and the read result FIFO.
interface read_request_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 89
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      mem_rd_valid;
  logic [ADDR_W-1:0]         mem_rd_addr;
  logic                      mem_rd_ready;
  logic                      fifo_empty;
  logic                      fifo_rd_en;
  logic [DATA_W-1:0]         fifo_dout;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic                      err_orphan;

  modport master (
    input  req_valid, req_addr, mem_rd_ready, fifo_empty, fifo_dout, rsp_ready,
    output req_ready, mem_rd_valid, mem_rd_addr, fifo_rd_en, rsp_valid, rsp_data, err_orphan
  );

  modport slave (
    output req_valid, req_addr, mem_rd_ready, fifo_empty, fifo_dout, rsp_ready,
    input  req_ready, mem_rd_valid, mem_rd_addr, fifo_rd_en, rsp_valid, rsp_data, err_orphan
  );
endinterface

// File: rtl/read_request_scheduler.sv
// Credit-based round-robin scheduler of requester reads onto one memory port; results
// are popped from the shared result FIFO in issue order and routed back by a tag queue.
module read_request_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 89,
  parameter int unsigned DEPTH   = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  read_request_scheduler_if.master bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {StArb, StHold} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   grant_q, rr_ptr_q, rsp_id_q;
  logic [ADDR_W-1:0] addr_q;
  logic              mem_valid_q;
  logic [CNT_W-1:0]  credits_q, tag_cnt_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [ID_W-1:0]   tag_mem_q [DEPTH];
  logic              pending_q, orphan_q;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx, cand;
  logic              issue, pop, tag_empty, rsp_accept;
  logic [DATA_W-1:0] rsp_data;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign issue      = mem_valid_q && bus.mem_rd_ready;
  assign tag_empty  = (tag_cnt_q == '0);
  assign rsp_accept = pending_q && bus.rsp_ready[rsp_id_q];
  assign pop        = !bus.fifo_empty && !tag_empty && (!pending_q || rsp_accept);

  assign bus.mem_rd_valid = mem_valid_q;
  assign bus.mem_rd_addr  = addr_q;
  assign bus.fifo_rd_en   = pop;
  assign rsp_data         = bus.fifo_dout;
  assign bus.rsp_data     = rsp_data;
  assign bus.err_orphan   = orphan_q;

  always_comb begin
    bus.req_ready = '0;
    if (mem_valid_q) bus.req_ready[grant_q] = bus.mem_rd_ready;
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (pending_q) bus.rsp_valid[rsp_id_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StArb;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      addr_q      <= '0;
      mem_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StArb: begin
          if (pick_found && credits_q != '0) begin
            grant_q     <= pick_idx;
            addr_q      <= bus.req_addr[32'(pick_idx)*ADDR_W +: ADDR_W];
            mem_valid_q <= 1'b1;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (bus.mem_rd_ready) begin
            mem_valid_q <= 1'b0;
            rr_ptr_q    <= (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
            state_q     <= StArb;
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits_q <= CNT_W'(DEPTH);
    end else if (issue && !pop) begin
      credits_q <= credits_q - CNT_W'(1);
    end else if (pop && !issue) begin
      credits_q <= credits_q + CNT_W'(1);
    end
  end

  // Tag storage carries no reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (issue) tag_mem_q[wr_ptr_q] <= grant_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_cnt_q <= '0;
    end else begin
      if (issue) wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      if (issue && !pop)      tag_cnt_q <= tag_cnt_q + CNT_W'(1);
      else if (pop && !issue) tag_cnt_q <= tag_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      rsp_id_q  <= '0;
      orphan_q  <= 1'b0;
    end else begin
      if (pop) begin
        rsp_id_q  <= tag_mem_q[rd_ptr_q];
        pending_q <= 1'b1;
      end else if (rsp_accept) begin
        pending_q <= 1'b0;
      end
      if (!bus.fifo_empty && tag_empty) orphan_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_read_request_scheduler.sv
// Randomized and directed bench for read_request_scheduler with a transaction-level
// reference model, a memory/FIFO environment and per-cycle output comparison.
module tb_read_request_scheduler;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned DATA_W  = 89;
  localparam int unsigned DEPTH   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  read_request_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  read_request_scheduler #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  // Environment knobs and state
  int cyc = 0;
  int req_pct = 0, mem_pct = 100, rsp_pct = 100, lat_min = 1, lat_max = 3;
  bit mem_hold = 1'b0;
  logic [NUM_REQ-1:0] rsp_block = '0;
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  int mem_t [$];
  logic [DATA_W-1:0] mem_d [$];
  int last_t = 0;
  logic [DATA_W-1:0] fifo_q [$];

  logic [NUM_REQ-1:0] hs_req;
  bit hs_mem, hs_pop;
  logic [ADDR_W-1:0] hs_addr;

  // Reference model: issued-but-undelivered results in order, plus arbiter view
  bit m_hold = 1'b0;
  int m_grant = 0, m_ptr = 0;
  bit m_pending = 1'b0, m_orphan = 1'b0;
  int sb_id [$];
  logic [DATA_W-1:0] sb_data [$];

  int issue_log [$];
  int rsp_log [$];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] f_data(logic [ADDR_W-1:0] a);
    return {a[24:0] ^ 25'h1A5A5A5, a};
  endfunction

  function automatic logic [NUM_REQ-1:0] oh(int i);
    return NUM_REQ'(1) << i;
  endfunction

  function automatic int idx_of(logic [NUM_REQ-1:0] v);
    for (int i = 0; i < int'(NUM_REQ); i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic pack_addr();
    for (int i = 0; i < int'(NUM_REQ); i++) bus.req_addr[i*ADDR_W +: ADDR_W] = addr_arr[i];
  endtask

  // Environment update, just after the active edge.
  task automatic edge_step();
    int t;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      fifo_q.delete();
      mem_t.delete();
      mem_d.delete();
      bus.req_valid = '0;
    end else begin
      if (hs_pop && fifo_q.size() > 0) bus.fifo_dout = fifo_q.pop_front();
      if (hs_mem) begin
        t = cyc + int'($urandom_range(lat_max, lat_min));
        if (t < last_t) t = last_t;
        last_t = t;
        mem_t.push_back(t);
        mem_d.push_back(f_data(hs_addr));
      end
      while (!mem_hold && mem_t.size() > 0 && mem_t[0] <= cyc) begin
        fifo_q.push_back(mem_d.pop_front());
        void'(mem_t.pop_front());
        chk("fifo_overflow", fifo_q.size() <= int'(DEPTH), 1);
      end
      bus.req_valid = bus.req_valid & ~hs_req;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!bus.req_valid[i] && int'($urandom_range(99)) < req_pct) begin
          bus.req_valid[i] = 1'b1;
          addr_arr[i] = {$urandom, $urandom};
        end
      end
    end
    pack_addr();
    bus.fifo_empty   = (fifo_q.size() == 0);
    bus.mem_rd_ready = int'($urandom_range(99)) < mem_pct;
    for (int i = 0; i < int'(NUM_REQ); i++)
      bus.rsp_ready[i] = !rsp_block[i] && int'($urandom_range(99)) < rsp_pct;
  endtask

  // Compare against the model mid-cycle, then advance the model across the next edge.
  task automatic check_step();
    int tags, fid, credits;
    bit exp_pop, issue, acc, orph;
    @(negedge clk);
    tags    = sb_id.size() - (m_pending ? 1 : 0);
    credits = int'(DEPTH) - tags;
    fid     = (sb_id.size() > 0) ? sb_id[0] : 0;
    exp_pop = !bus.fifo_empty && tags > 0 && (!m_pending || bus.rsp_ready[fid]);
    if (checking) begin
      chk("mem_rd_valid", bus.mem_rd_valid, m_hold);
      if (m_hold) chk("mem_rd_addr", bus.mem_rd_addr, addr_arr[m_grant]);
      chk("req_ready", bus.req_ready, (m_hold && bus.mem_rd_ready) ? oh(m_grant) : '0);
      chk("fifo_rd_en", bus.fifo_rd_en, exp_pop);
      chk("rsp_valid", bus.rsp_valid, m_pending ? oh(fid) : '0);
      if (m_pending) chk("rsp_data", bus.rsp_data, sb_data[0]);
      chk("err_orphan", bus.err_orphan, m_orphan);
      chk("credits", dut.credits_q, credits);
    end
    hs_req  = bus.req_valid & bus.req_ready;
    hs_mem  = bus.mem_rd_valid && bus.mem_rd_ready;
    hs_addr = bus.mem_rd_addr;
    hs_pop  = bus.fifo_rd_en;
    if (hs_mem) issue_log.push_back(idx_of(bus.req_ready));
    if ((bus.rsp_valid & bus.rsp_ready) != '0) rsp_log.push_back(idx_of(bus.rsp_valid));

    if (!rst_n) begin
      m_hold = 1'b0; m_ptr = 0; m_pending = 1'b0; m_orphan = 1'b0;
      sb_id.delete(); sb_data.delete();
    end else begin
      issue = m_hold && bus.mem_rd_ready;
      acc   = m_pending && bus.rsp_ready[fid];
      orph  = !bus.fifo_empty && tags == 0;
      if (acc) begin
        void'(sb_id.pop_front());
        void'(sb_data.pop_front());
      end
      if (exp_pop) m_pending = 1'b1;
      else if (acc) m_pending = 1'b0;
      if (issue) begin
        sb_id.push_back(m_grant);
        sb_data.push_back(f_data(addr_arr[m_grant]));
        m_ptr  = (m_grant + 1) % int'(NUM_REQ);
        m_hold = 1'b0;
      end else if (!m_hold && credits > 0 && bus.req_valid != '0) begin
        for (int k = 0; k < int'(NUM_REQ); k++) begin
          if (!m_hold && bus.req_valid[(m_ptr + k) % int'(NUM_REQ)]) begin
            m_grant = (m_ptr + k) % int'(NUM_REQ);
            m_hold  = 1'b1;
          end
        end
      end
      if (orph) m_orphan = 1'b1;
    end
  endtask

  task automatic cycle();
    edge_step();
    check_step();
  endtask

  task automatic drain();
    bit done = 1'b0;
    req_pct = 0; mem_hold = 1'b0; rsp_block = '0; rsp_pct = 100; mem_pct = 100;
    for (int i = 0; i < 300 && !done; i++) begin
      if (bus.req_valid == '0 && !m_hold && sb_id.size() == 0 && fifo_q.size() == 0 &&
          mem_t.size() == 0) done = 1'b1;
      else cycle();
    end
    chk("drain_done", done, 1);
  endtask

  task automatic issue_one(int id, logic [ADDR_W-1:0] a);
    bit done = 1'b0;
    edge_step();
    bus.req_valid[id] = 1'b1;
    addr_arr[id] = a;
    pack_addr();
    check_step();
    for (int i = 0; i < 12 && !done; i++) begin
      cycle();
      if (hs_mem) done = 1'b1;
    end
    chk("issue_done", done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rr_exp [5];
    int bp_exp [3];
    int since;
    bit found;
    rr_exp = '{0, 1, 2, 3, 0};
    bp_exp = '{1, 3, 1};
    bus.req_valid = '0; bus.mem_rd_ready = 1'b0; bus.fifo_empty = 1'b1;
    bus.fifo_dout = '0; bus.rsp_ready = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) addr_arr[i] = '0;
    pack_addr();
    hs_req = '0; hs_mem = 1'b0; hs_pop = 1'b0; hs_addr = '0;

    // Reset state
    repeat (3) cycle();
    edge_step();
    rst_n = 1'b1;
    checking = 1'b1;
    check_step();
    chk("rst_mem_rd_valid", bus.mem_rd_valid, 0);
    chk("rst_mem_rd_addr", bus.mem_rd_addr, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_fifo_rd_en", bus.fifo_rd_en, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_err_orphan", bus.err_orphan, 0);
    chk("rst_credits", dut.credits_q, 8);

    // Round-robin from rr_ptr = 0
    issue_log.delete();
    req_pct = 100; mem_pct = 100; rsp_pct = 100; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 40 && issue_log.size() < 5; i++) cycle();
    chk("rr_count", issue_log.size() >= 5, 1);
    if (issue_log.size() >= 5)
      for (int k = 0; k < 5; k++) chk($sformatf("rr_order[%0d]", k), issue_log[k], rr_exp[k]);
    drain();

    // Single request from requester 2
    edge_step();
    bus.req_valid[2] = 1'b1;
    addr_arr[2] = 64'h1000;
    pack_addr();
    check_step();
    chk("single_arb_cycle_valid", bus.mem_rd_valid, 0);
    cycle();
    chk("single_mem_rd_valid", bus.mem_rd_valid, 1);
    chk("single_mem_rd_addr", bus.mem_rd_addr, 64'h1000);
    chk("single_req_ready", bus.req_ready, 4'b0100);
    cycle();
    chk("single_credits_after_issue", dut.credits_q, 7);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (bus.rsp_valid != '0) found = 1'b1;
    end
    chk("single_rsp_seen", found, 1);
    chk("single_rsp_valid", bus.rsp_valid, 4'b0100);
    chk("single_rsp_data", bus.rsp_data, {25'h1A5B5A5, 64'h0000_0000_0000_1000});
    chk("single_credits_after_pop", dut.credits_q, 8);
    drain();

    // Ordering under backpressure on requester 3
    rsp_log.delete();
    rsp_block = 4'b1000; lat_min = 1; lat_max = 1;
    issue_one(1, 64'hA000);
    issue_one(3, 64'hB000);
    issue_one(1, 64'hC000);
    repeat (5) cycle();
    rsp_block = '0;
    drain();
    chk("bp_count", rsp_log.size(), 3);
    if (rsp_log.size() == 3)
      for (int k = 0; k < 3; k++) chk($sformatf("bp_order[%0d]", k), rsp_log[k], bp_exp[k]);

    // Credit exhaustion and refill
    issue_log.delete();
    mem_hold = 1'b1; req_pct = 100; mem_pct = 100; lat_min = 1; lat_max = 2;
    for (int i = 0; i < 60 && issue_log.size() < 8; i++) cycle();
    repeat (4) cycle();
    chk("exh_issue_count", issue_log.size(), 8);
    chk("exh_mem_rd_valid", bus.mem_rd_valid, 0);
    chk("exh_credits", dut.credits_q, 0);
    mem_hold = 1'b0;
    since = -1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (since >= 0) since++;
      if (since < 0 && hs_pop) since = 0;
      else if (since > 0 && bus.mem_rd_valid) found = 1'b1;
    end
    chk("refill_latency", since, 2);
    drain();

    // Randomized traffic
    for (int r = 0; r < 6; r++) begin
      req_pct = int'($urandom_range(100, 10));
      mem_pct = int'($urandom_range(100, 20));
      rsp_pct = int'($urandom_range(100, 10));
      lat_min = 1;
      lat_max = int'($urandom_range(8, 1));
      repeat (400) cycle();
      drain();
    end

    // Reset with outstanding tags and a pending result
    req_pct = 100; mem_pct = 100; rsp_pct = 0; lat_min = 1; lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      if (m_pending && sb_id.size() >= 4) found = 1'b1;
    end
    chk("midrst_setup", found, 1);
    edge_step();
    rst_n = 1'b0;
    check_step();
    edge_step();
    rst_n = 1'b1;
    req_pct = 0;
    check_step();
    chk("midrst_mem_rd_valid", bus.mem_rd_valid, 0);
    chk("midrst_req_ready", bus.req_ready, 0);
    chk("midrst_fifo_rd_en", bus.fifo_rd_en, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_err_orphan", bus.err_orphan, 0);
    chk("midrst_credits", dut.credits_q, 8);
    chk("midrst_tag_cnt", dut.tag_cnt_q, 0);

    // Stray FIFO data with no outstanding tag
    edge_step();
    fifo_q.push_back(89'h1_2345_6789);
    bus.fifo_empty = 1'b0;
    check_step();
    chk("orphan_no_pop", bus.fifo_rd_en, 0);
    cycle();
    chk("orphan_set", bus.err_orphan, 1);
    repeat (2) cycle();
    chk("orphan_sticky", bus.err_orphan, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
